// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and default frame shape.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: oversample tick and serial pin in, host read handshake and status out.
interface uart_receiver_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic                 en;
  logic                 rx;
  logic                 rd_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output en, rx, rd_en,
    input  rx_data, rx_ready, frame_err, overrun, busy
  );

  modport slave (
    input  en, rx, rd_en,
    output rx_data, rx_ready, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; both flops reset to RESET_VAL.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronised rx, mid-bit start validation, LSB-first data capture,
// stop-bit check with frame error / overrun reporting, and a held byte until read.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input logic            clk,
  input logic            reset,
  uart_receiver_if.slave bus
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_ready_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 busy_q;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.rd_en) begin
        rx_ready_q <= 1'b0;
        overrun_q  <= 1'b0;
      end

      if (bus.en) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              tick_cnt <= '0;
              busy_q   <= 1'b1;
            end
          end

          ST_START: begin
            if (tick_cnt == HALF_LAST) begin
              if (!rx_s) begin
                state    <= ST_DATA;
                tick_cnt <= '0;
                bit_idx  <= '0;
              end else begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              shift[bit_idx] <= rx_s;
              tick_cnt       <= '0;
              if (bit_idx == LAST_BIT) state <= ST_STOP;
              else                     bit_idx <= bit_idx + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                // New byte overrides a coincident read: ready stays set, overrun is dropped.
                rx_data_q  <= shift;
                rx_ready_q <= 1'b1;
                overrun_q  <= bus.rd_en ? 1'b0 : (overrun_q | rx_ready_q);
                state      <= ST_IDLE;
                busy_q     <= 1'b0;
              end else begin
                frame_err_q <= 1'b1;
                state       <= ST_BRK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end

          ST_BRK: begin
            if (rx_s) begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end

          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16 with en every 4 clk, so one bit is 64 clk.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned fe_cnt = 0;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_err === 1'b1) fe_cnt++;

  initial begin
    bus.en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start bit plus data bits, LSB first; leaves the line at the last data bit.
  task automatic send_data(input logic [7:0] b);
    bus.rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      wait_clks(BIT_CLKS);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_data(b);
    bus.rx = 1'b1;
    wait_clks(BIT_CLKS);
  endtask

  task automatic read_pulse();
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned fe_before;
    logic got;
    bus.rx    = 1'b1;
    bus.rd_en = 1'b0;
    reset     = 1'b1;
    wait_clks(4);
    check("reset_rx_data",   32'(bus.rx_data),   32'h0);
    check("reset_rx_ready",  32'(bus.rx_ready),  32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_overrun",   32'(bus.overrun),   32'h0);
    check("reset_busy",      32'(bus.busy),      32'h0);
    reset = 1'b0;
    wait_clks(BIT_CLKS);

    // 1: clean frame 0xA5
    send_frame(8'hA5);
    check("t1_rx_ready",  32'(bus.rx_ready), 32'h1);
    check("t1_rx_data",   32'(bus.rx_data),  32'hA5);
    check("t1_frame_err", 32'(fe_cnt),       32'h0);
    check("t1_busy",      32'(bus.busy),     32'h0);
    check("t1_overrun",   32'(bus.overrun),  32'h0);
    read_pulse();
    check("t1_read_clears", 32'(bus.rx_ready), 32'h0);

    // 2: 4-tick glitch is rejected at the mid-bit check
    bus.rx = 1'b0;
    wait_clks(16);
    check("t2_busy_in_start", 32'(bus.busy), 32'h1);
    bus.rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("t2_busy_idle", 32'(bus.busy),     32'h0);
    check("t2_rx_ready",  32'(bus.rx_ready), 32'h0);
    check("t2_no_fe",     32'(fe_cnt),       32'h0);

    // 3: bad stop bit with line held low, then recovery
    fe_before = fe_cnt;
    send_data(8'h3C);
    bus.rx = 1'b0;
    wait_clks(40 * 4);
    check("t3_fe_once",      32'(fe_cnt - fe_before), 32'h1);
    check("t3_rx_ready",     32'(bus.rx_ready),       32'h0);
    check("t3_data_kept",    32'(bus.rx_data),        32'hA5);
    check("t3_busy_in_brk",  32'(bus.busy),           32'h1);
    bus.rx = 1'b1;
    wait_clks(16);
    check("t3_busy_release", 32'(bus.busy), 32'h0);
    wait_clks(BIT_CLKS);
    send_frame(8'h5A);
    check("t3_rx_data",  32'(bus.rx_data),  32'h5A);
    check("t3_rx_ready", 32'(bus.rx_ready), 32'h1);
    read_pulse();

    // 4: overrun on two unread frames
    send_frame(8'h11);
    check("t4_first_ovr", 32'(bus.overrun), 32'h0);
    send_frame(8'h22);
    check("t4_rx_data",  32'(bus.rx_data),  32'h22);
    check("t4_rx_ready", 32'(bus.rx_ready), 32'h1);
    check("t4_overrun",  32'(bus.overrun),  32'h1);
    read_pulse();
    check("t4_ready_clr",   32'(bus.rx_ready), 32'h0);
    check("t4_overrun_clr", 32'(bus.overrun),  32'h0);

    // 5: back-to-back extremes
    fe_before = fe_cnt;
    send_frame(8'h00);
    check("t5_data_00",  32'(bus.rx_data),  32'h00);
    check("t5_ready_00", 32'(bus.rx_ready), 32'h1);
    read_pulse();
    send_frame(8'hFF);
    check("t5_data_ff",  32'(bus.rx_data),  32'hFF);
    check("t5_ready_ff", 32'(bus.rx_ready), 32'h1);
    read_pulse();
    check("t5_no_fe", 32'(fe_cnt - fe_before), 32'h0);

    // 7: rd_en held through the stop sample; new byte wins
    send_frame(8'h33);
    send_data(8'hC3);
    bus.rx    = 1'b1;
    bus.rd_en = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    bus.rd_en = 1'b0;
    check("t7_ready_seen", 32'(got),          32'h1);
    check("t7_rx_ready",   32'(bus.rx_ready), 32'h1);
    check("t7_overrun",    32'(bus.overrun),  32'h0);
    check("t7_rx_data",    32'(bus.rx_data),  32'hC3);
    wait_clks(BIT_CLKS);
    send_frame(8'h44);
    check("t7_overrun_set", 32'(bus.overrun), 32'h1);

    // 6: reset in the middle of data bit 4 of 0x96
    bus.rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i == 1 || i == 2);
      wait_clks(BIT_CLKS);
    end
    bus.rx = 1'b1;
    wait_clks(BIT_CLKS / 2);
    check("t6_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    wait_clks(2);
    check("t6_rx_data",   32'(bus.rx_data),   32'h0);
    check("t6_rx_ready",  32'(bus.rx_ready),  32'h0);
    check("t6_frame_err", 32'(bus.frame_err), 32'h0);
    check("t6_overrun",   32'(bus.overrun),   32'h0);
    check("t6_busy",      32'(bus.busy),      32'h0);
    reset = 1'b0;
    wait_clks(2 * BIT_CLKS);
    check("t6_idle_after", 32'(bus.busy), 32'h0);
    send_frame(8'h96);
    check("t6_data_96",  32'(bus.rx_data),  32'h96);
    check("t6_ready_96", 32'(bus.rx_ready), 32'h1);
    check("t6_ovr_96",   32'(bus.overrun),  32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
